// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and widths for the LC-3 datapath
package lc3_pkg;
    localparam int WORD_W      = 16;
    localparam int SRAM_ADDR_W = 20;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: internal bus, SRAM pin and status signals of the memory access unit
interface mem_access_unit_if import lc3_pkg::*; #(parameter int ADDR_W = SRAM_ADDR_W) ();
    logic [WORD_W-1:0] bus_in;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] MDR_data;
    logic [WORD_W-1:0] MAR_out;
    logic [ADDR_W-1:0] ADDR;
    logic [WORD_W-1:0] Data_to_SRAM;
    logic              data_oe;
    logic [WORD_W-1:0] Data_from_SRAM;
    logic              CE_n;
    logic              OE_n;
    logic              WE_n;
    logic              mem_busy;
    logic              mem_done;
    modport master (
        output bus_in, LD_MAR, LD_MDR, mem_req, mem_we, Data_from_SRAM,
        input  MDR_data, MAR_out, ADDR, Data_to_SRAM, data_oe, CE_n, OE_n, WE_n, mem_busy, mem_done
    );
    modport slave (
        input  bus_in, LD_MAR, LD_MDR, mem_req, mem_we, Data_from_SRAM,
        output MDR_data, MAR_out, ADDR, Data_to_SRAM, data_oe, CE_n, OE_n, WE_n, mem_busy, mem_done
    );
endinterface

// File: rtl/mem_access_unit_reg_16.sv
// reg_16: 16-bit register with load enable and asynchronous active-low reset
module reg_16 import lc3_pkg::*; (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_ld,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_q
);
    // hold value unless loaded
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) o_q <= '0;
        else if (i_ld) o_q <= i_d;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR registers and SRAM read/write cycle sequencer with wait states
module mem_access_unit import lc3_pkg::*; #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = SRAM_ADDR_W
) (
    input  logic         Clk,
    input  logic         Reset,
    mem_access_unit_if.slave bus
);
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be within 1..15");
    end

    mem_state_t        r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we, r_ce_n, r_oe_n, r_we_n, r_data_oe, r_busy, r_done;
    logic [WORD_W-1:0] w_mar, w_mdr, w_mdr_d;
    logic              w_idle, w_start, w_last, w_cap, w_mdr_ld;

    assign w_idle   = r_state == IDLE;
    assign w_start  = w_idle && bus.mem_req;
    assign w_last   = r_state == ACCESS && r_cnt == 4'd1;
    assign w_cap    = w_last && !r_we;
    assign w_mdr_ld = (w_idle && bus.LD_MDR) || w_cap;
    assign w_mdr_d  = w_cap ? bus.Data_from_SRAM : bus.bus_in;

    reg_16 u_mar (.Clk(Clk), .Reset(Reset), .i_ld(w_idle && bus.LD_MAR), .i_d(bus.bus_in), .o_q(w_mar));
    reg_16 u_mdr (.Clk(Clk), .Reset(Reset), .i_ld(w_mdr_ld), .i_d(w_mdr_d), .o_q(w_mdr));

    // next state: IDLE -> ACCESS on request, ACCESS -> DONE on last wait cycle, DONE -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.mem_req ? ACCESS : IDLE;
            ACCESS:  w_next = (r_cnt == 4'd1) ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    // state register with busy/done status registered alongside it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != IDLE;
            r_done  <= w_next == DONE;
        end
    end

    // wait counter, latched address/type and SRAM strobes; access type is frozen at acceptance
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_data_oe <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= 4'(WAIT_CYCLES);
            r_addr    <= ADDR_W'(w_mar);
            r_we      <= bus.mem_we;
            r_ce_n    <= 1'b0;
            r_oe_n    <= bus.mem_we;
            r_we_n    <= !bus.mem_we;
            r_data_oe <= bus.mem_we;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_last) begin
                r_ce_n    <= 1'b1;
                r_oe_n    <= 1'b1;
                r_we_n    <= 1'b1;
                r_data_oe <= 1'b0;
            end
        end
    end

    assign bus.MDR_data     = w_mdr;
    assign bus.MAR_out      = w_mar;
    assign bus.Data_to_SRAM = w_mdr;
    assign bus.ADDR         = r_addr;
    assign bus.CE_n         = r_ce_n;
    assign bus.OE_n         = r_oe_n;
    assign bus.WE_n         = r_we_n;
    assign bus.data_oe      = r_data_oe;
    assign bus.mem_busy     = r_busy;
    assign bus.mem_done     = r_done;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of the memory access unit against a word-level model
module tb_mem_access_unit;
    localparam int W = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_access_unit_if u_if ();
    mem_access_unit #(.WAIT_CYCLES(W), .ADDR_W(20)) dut (.Clk(Clk), .Reset(Reset), .bus(u_if));

    always #5 Clk = ~Clk;

    // word-level model: architectural MAR/MDR and memory contents
    logic [15:0] mar = 16'h0;
    logic [15:0] mdr = 16'h0;
    logic [15:0] ref_mem [logic [19:0]];
    // SRAM device contents as written by the DUT's strobes
    logic [15:0] sram [logic [19:0]];
    logic        pw = 1'b1;

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] * 16'h9E37 ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] sram_rd(input logic [19:0] a);
        return sram.exists(a) ? sram[a] : init_val(a);
    endfunction

    // SRAM device: drives read data while selected, commits a write when WE_n rises outside reset
    always @(negedge Clk) begin
        if (!pw && u_if.WE_n && Reset) sram[u_if.ADDR] = u_if.Data_to_SRAM;
        pw = u_if.WE_n;
        u_if.Data_from_SRAM = (!u_if.CE_n && !u_if.OE_n) ? sram_rd(u_if.ADDR) : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_strobes"}, {29'd0, u_if.CE_n, u_if.OE_n, u_if.WE_n}, 32'd7);
        chk({tag, "_status"}, {29'd0, u_if.data_oe, u_if.mem_busy, u_if.mem_done}, 32'd0);
    endtask

    task automatic load_mar(input logic [15:0] v);
        u_if.bus_in = v; u_if.LD_MAR = 1'b1;
        @(posedge Clk); #1 u_if.LD_MAR = 1'b0;
        mar = v;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        u_if.bus_in = v; u_if.LD_MDR = 1'b1;
        @(posedge Clk); #1 u_if.LD_MDR = 1'b0;
        mdr = v;
    endtask

    // one full access: request at edge 0, then observe cycles 1..W+2 as bit masks
    task automatic access(input logic we, input logic noise, input logic ld_mar, input logic [15:0] nv);
        logic [31:0] ce_m = 0, oe_m = 0, we_m = 0, doe_m = 0, done_m = 0, busy_m = 0;
        logic [31:0] strobe = ((32'd1 << W) - 1) << 1;
        logic        stable = 1'b1;
        logic [15:0] a = mar;
        u_if.bus_in = nv; u_if.LD_MAR = ld_mar; u_if.mem_req = 1'b1; u_if.mem_we = we;
        @(posedge Clk); #1;
        u_if.LD_MAR = 1'b0; u_if.mem_req = 1'b0;
        if (ld_mar) mar = nv;
        chk("addr", 32'(u_if.ADDR), {16'd0, a});
        chk("mar_out", 32'(u_if.MAR_out), 32'(mar));
        for (int c = 1; c <= W + 2; c++) begin
            if (noise && c == 1) begin
                u_if.bus_in = 16'hFFFF; u_if.LD_MDR = 1'b1; u_if.LD_MAR = 1'b1;
                u_if.mem_req = 1'b1; u_if.mem_we = !we;
            end
            @(negedge Clk);
            ce_m   |= 32'(!u_if.CE_n) << c;
            oe_m   |= 32'(!u_if.OE_n) << c;
            we_m   |= 32'(!u_if.WE_n) << c;
            doe_m  |= 32'(u_if.data_oe) << c;
            done_m |= 32'(u_if.mem_done) << c;
            busy_m |= 32'(u_if.mem_busy) << c;
            if (c <= W && u_if.Data_to_SRAM !== mdr) stable = 1'b0;
            @(posedge Clk); #1;
            u_if.LD_MDR = 1'b0; u_if.LD_MAR = 1'b0; u_if.mem_req = 1'b0;
        end
        if (we) ref_mem[20'(a)] = mdr;
        else mdr = ref_rd(20'(a));
        chk("ce_mask", ce_m, strobe);
        chk("oe_mask", oe_m, we ? 32'd0 : strobe);
        chk("we_mask", we_m, we ? strobe : 32'd0);
        chk("doe_mask", doe_m, we ? strobe : 32'd0);
        chk("done_mask", done_m, 32'd1 << (W + 1));
        chk("busy_mask", busy_m, ((32'd1 << (W + 1)) - 1) << 1);
        chk("wdata_stable", 32'(stable), 32'd1);
        chk("mdr", 32'(u_if.MDR_data), 32'(mdr));
        chk("mar_after", 32'(u_if.MAR_out), 32'(mar));
        chk("sram", 32'(sram_rd(20'(a))), 32'(ref_rd(20'(a))));
    endtask

    initial begin
        logic [31:0] done_m;
        logic [19:0] ra;
        u_if.bus_in = 16'h0; u_if.LD_MAR = 1'b0; u_if.LD_MDR = 1'b0;
        u_if.mem_req = 1'b0; u_if.mem_we = 1'b0;

        // reset, then idle with no requests
        repeat (2) @(negedge Clk);
        idle_chk("rst");
        chk("rst_regs", {u_if.MAR_out, u_if.MDR_data}, 32'd0);
        chk("rst_addr", 32'(u_if.ADDR), 32'd0);
        @(posedge Clk); #1 Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            idle_chk("idle");
            chk("idle_regs", {u_if.MAR_out, u_if.MDR_data}, 32'd0);
        end
        @(posedge Clk); #1;

        // directed read of 0x03000
        sram[20'h03000] = 16'hBEEF; ref_mem[20'h03000] = 16'hBEEF;
        load_mar(16'h3000);
        access(1'b0, 1'b0, 1'b0, 16'h0);
        chk("read_beef", 32'(u_if.MDR_data), 32'h0000BEEF);

        // directed write of 0x1234 to 0x00042
        load_mar(16'h0042);
        load_mdr(16'h1234);
        access(1'b1, 1'b0, 1'b0, 16'h0);
        chk("write_1234", 32'(sram_rd(20'h00042)), 32'h00001234);

        // loads, request and type change while busy are all ignored
        load_mar(16'h0077);
        access(1'b0, 1'b1, 1'b0, 16'h0);
        chk("ignore_ffff", 32'(u_if.MDR_data), 32'(init_val(20'h00077)));

        // simultaneous MAR load and request uses the old MAR
        load_mar(16'h0010);
        access(1'b0, 1'b0, 1'b1, 16'h0020);
        chk("simul_mar", 32'(u_if.MAR_out), 32'h00000020);

        // random mix of loads, reads and writes over a small address range
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: load_mar(16'($urandom_range(0, 7)));
                1: load_mdr(16'($urandom));
                2: access(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)));
                default: access(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)));
            endcase
        end

        // reset asserted during the first strobe cycle of a write
        load_mar(16'h0055);
        load_mdr(16'hA5A5);
        ra = 20'h00055;
        u_if.mem_req = 1'b1; u_if.mem_we = 1'b1;
        @(posedge Clk); #1 u_if.mem_req = 1'b0;
        chk("midw_we_on", {30'd0, u_if.WE_n, u_if.data_oe}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("midw_async", {28'd0, u_if.CE_n, u_if.WE_n, u_if.data_oe, u_if.mem_busy}, 32'hC);
        @(negedge Clk);
        @(posedge Clk); #1 Reset = 1'b1;
        mar = 16'h0; mdr = 16'h0;
        done_m = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            done_m |= 32'(u_if.mem_done) << c;
        end
        chk("midw_no_done", done_m, 32'd0);
        chk("midw_no_write", 32'(sram_rd(ra)), 32'(ref_rd(ra)));
        chk("midw_regs", {u_if.MAR_out, u_if.MDR_data}, 32'd0);
        idle_chk("midw_idle");
        @(posedge Clk); #1;
        access(1'b0, 1'b0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Holds MAR and MDR for the LC-3 datapath and sequences SRAM read/write cycles.
- Consumes the 16-bit internal bus value through MAR and MDR loads.
- Produces MDR_data, which the bus mux gates onto the bus under GateMDR.
- Runs a small FSM with a programmable wait-state counter, and reports busy and done status to the control unit.

Parameters:
- WAIT_CYCLES, 2: number of cycles SRAM strobes are held per access. Legal range is 1..15.
- ADDR_W, 20: SRAM address width. The upper bits are zero-extended from MAR.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- bus_in  in  16  current internal bus value.
- LD_MAR  in  1  load MAR from bus_in.
- LD_MDR  in  1  load MDR from bus_in.
- mem_req  in  1  start a memory access, sampled in IDLE only.
- mem_we  in  1  access type sampled with mem_req: 1 = write, 0 = read.
- MDR_data  out  16  MDR contents, feeds the bus mux.
- MAR_out  out  16  MAR contents, for debug and hex display.
- ADDR  out  ADDR_W  SRAM address, registered.
- Data_to_SRAM  out  16  write data, equal to MDR.
- data_oe  out  1  top-level tri-state enable for the SRAM data pins.
- Data_from_SRAM  in  16  read data.
- CE_n  out  1  SRAM chip enable, active-low.
- OE_n  out  1  SRAM output enable, active-low.
- WE_n  out  1  SRAM write enable, active-low.
- mem_busy  out  1  access in progress.
- mem_done  out  1  one-cycle pulse on access completion.

Behaviour:
- Reset (asynchronous, Reset=0):
  - Takes effect immediately, even mid-access.
  - MAR=0, MDR=0, ADDR=0, CE_n=OE_n=WE_n=1, data_oe=0, mem_busy=0, mem_done=0, counter=0, state=IDLE.
  - No partial write completes after reset asserts.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - On mem_req=1: ADDR<={zero-ext, MAR current value}, CE_n<=0, counter<=WAIT_CYCLES. State goes to ACCESS.
  - Read: OE_n<=0.
  - Write: WE_n<=0 and data_oe<=1.
- ACCESS:
  - counter decrements each cycle.
  - When counter==1: read captures MDR<=Data_from_SRAM. CE_n, OE_n, WE_n go to 1 and data_oe to 0. State goes to DONE.
- DONE: mem_done=1 for exactly one cycle, then state returns to IDLE.
- Latency: if mem_req is sampled at edge 0, strobes are active for cycles 1..WAIT_CYCLES. mem_done is high in cycle WAIT_CYCLES+1. The earliest next request is accepted at edge WAIT_CYCLES+2.
- mem_busy=1 in ACCESS and DONE, 0 in IDLE. It is registered alongside state.
- MAR loads bus_in when LD_MAR=1 and state=IDLE. LD_MAR is ignored otherwise.
- MDR loads bus_in when LD_MDR=1 and state=IDLE. LD_MDR is ignored during ACCESS and DONE, so it cannot conflict with the read capture.
- LD_MAR and mem_req in the same IDLE cycle: the access uses the old MAR, and MAR updates to bus_in at that edge.
- mem_req while busy is ignored; it is not queued.
- mem_we is sampled only with an accepted mem_req. Changes during ACCESS have no effect.
- Write data: Data_to_SRAM mirrors MDR continuously. MDR is frozen during ACCESS, so write data is stable across the whole strobe window.
- Outputs MDR_data and MAR_out are direct register outputs with no combinational path from inputs.
- Counter width is 4 bits. WAIT_CYCLES outside 1..15 is a configuration error, flagged by an elaboration-time assertion.

Decomposition:
- Shared package lc3_pkg holds:
  - enum mem_state_t {IDLE, ACCESS, DONE};
  - WORD_W=16;
  - SRAM_ADDR_W=20.
- One natural sub-module: reg_16, a 16-bit register with load enable and async active-low reset, instantiated for MAR and MDR.
- FSM, counter and strobe registers stay in the top module.

Test Plan:
- Reset then idle: drive Reset=0 then 1 with no requests -> MAR=0, MDR=0, CE_n=OE_n=WE_n=1, mem_busy=0, data_oe=0 throughout.
- Read, WAIT_CYCLES=2:
  - Stimulus: bus_in=16'h3000 with LD_MAR; model SRAM[0x03000]=16'hBEEF; mem_req=1, mem_we=0 at edge 0.
  - Response: CE_n=OE_n=0 in cycles 1-2, ADDR=20'h03000, MDR_data=16'hBEEF after edge 2, mem_done=1 only in cycle 3.
- Write:
  - Stimulus: MAR=16'h0042, LD_MDR with bus_in=16'h1234, mem_req=1, mem_we=1.
  - Response: WE_n=0 and data_oe=1 for exactly 2 cycles, Data_to_SRAM=16'h1234 stable, SRAM[0x00042]=16'h1234 afterwards.
- Ignored inputs while busy: pulse LD_MDR with bus_in=16'hFFFF and mem_req during ACCESS of a read -> MDR ends as SRAM data, not FFFF. Exactly one mem_done, and no second access starts.
- Simultaneous load and request: MAR=16'h0010, then in one IDLE cycle LD_MAR with bus_in=16'h0020 plus mem_req -> ADDR=20'h00010, MAR_out=16'h0020 after the edge.
- Reset mid-write: assert Reset in cycle 1 of a write -> WE_n=1, CE_n=1, data_oe=0 immediately (before the next clock), state IDLE, mem_done never pulses.
